// File: rtl/hd44780_ram_reader.sv
// hd44780_ram_reader: walks an HD44780 command list held in RAM and hands each word to an LCD driver.
// Define HD44780_RAM_READER_DELAY_EN to run delay words (bit 14) as timed waits instead of emitting them.
module hd44780_ram_reader #(
    parameter int addr_width = 8,
    parameter int data_width = 16,
    parameter int delay_unit = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [addr_width-1:0] start_addr,
    output logic [addr_width-1:0] raddr,
    input  logic [data_width-1:0] rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_byte,
    output logic                  out_rs,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, EMIT, DELAY, FINISH} state_t;

    state_t                r_state, w_next;
    logic [addr_width-1:0] r_raddr;
    logic [addr_width:0]   r_cnt;
    logic [8:0]            r_word;
    logic                  r_err;
    logic                  w_is_dly, w_dly_end, w_adv, w_unused_rdata;

    assign w_unused_rdata = ^rdata;

`ifdef HD44780_RAM_READER_DELAY_EN
    localparam int DLY_W = 8 + $clog2(delay_unit + 1);
    logic [DLY_W-1:0] r_dly;
    assign w_is_dly  = rdata[14];
    assign w_dly_end = (r_state == DELAY) && (r_dly == '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dly <= '0;
        else if (r_state == LATCH)
            r_dly <= DLY_W'(rdata[7:0]) * DLY_W'(delay_unit);
        else if (r_state == DELAY && r_dly != '0)
            r_dly <= r_dly - DLY_W'(1);
    end
`else
    assign w_is_dly  = 1'b0;
    assign w_dly_end = 1'b0;
`endif

    assign w_adv     = (r_state == EMIT && out_ready) || w_dly_end;
    assign raddr     = r_raddr;
    assign out_valid = (r_state == EMIT);
    assign out_byte  = r_word[7:0];
    assign out_rs    = r_word[8];
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FINISH);
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // End marker outranks the delay flag; a full address-space sweep aborts before re-reading.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? FETCH : IDLE;
            FETCH:   w_next = r_cnt[addr_width] ? FINISH : LATCH;
            LATCH:   w_next = rdata[15] ? FINISH : w_is_dly ? DELAY : EMIT;
            EMIT:    w_next = out_ready ? FETCH : EMIT;
            DELAY:   w_next = w_dly_end ? FETCH : DELAY;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_raddr <= start_addr;
                r_cnt   <= '0;
                r_err   <= 1'b0;
            end
            if (r_state == LATCH && w_next == EMIT)
                r_word <= rdata[8:0];
            if (r_state == FETCH && r_cnt[addr_width])
                r_err <= 1'b1;
            if (w_adv) begin
                r_raddr <= r_raddr + addr_width'(1);
                r_cnt   <= r_cnt + (addr_width + 1)'(1);
            end
        end
    end
endmodule
